// File: rtl/pifo_pop_ctrl_pkg.sv
// Shared widths, per-flow state and descriptor types, FSM encoding and the priority-decay rule
// for the PIFO feeder/pop controller.
package pifo_pop_ctrl_pkg;

    localparam int NUM_FLOWS     = 16;
    localparam int MAX_PRIORITY  = 256;
    localparam int BACKLOG_WIDTH = 8;
    localparam int INIT_PRIO     = 255;
    localparam int PRIO_STEP     = 16;
    localparam int PRIO_WIDTH    = $clog2(MAX_PRIORITY);
    localparam int FIDW          = $clog2(NUM_FLOWS);

    typedef logic [PRIO_WIDTH-1:0]    prio_t;
    typedef logic [FIDW-1:0]          flow_t;
    typedef logic [BACKLOG_WIDTH-1:0] backlog_t;

    typedef struct packed {
        backlog_t backlog;
        logic     active;
    } flow_state_t;

    typedef struct packed {
        flow_t flow;
        prio_t prio;
    } tx_desc_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Priority 0 means "no reinsert" on the PIFO side, so decay bottoms out at 1.
    function automatic prio_t decay_prio(input prio_t p);
        return (p > prio_t'(PRIO_STEP)) ? p - prio_t'(PRIO_STEP) : prio_t'(1);
    endfunction

endpackage

// File: rtl/pifo_pop_ctrl_if.sv
// Handshake bundle between the pop controller (master) and its surroundings: enqueue
// notifications, the pifo_set push/pop ports and the egress descriptor port.
interface pifo_pop_ctrl_if;
    import pifo_pop_ctrl_pkg::*;

    logic  enq_valid;
    flow_t enq_flow;
    logic  enq_ready;

    logic  push_valid;
    prio_t push_priority;
    flow_t push_data;
    logic  push_ready;

    logic  pop_valid;
    prio_t pop_priority;
    flow_t pop_data;
    logic  pop;
    prio_t reinsert_priority;
    logic  clear_all;

    logic  tx_valid;
    flow_t tx_flow;
    prio_t tx_priority;
    logic  tx_ready;

    logic  flush;

    modport master (
        input  enq_valid, enq_flow, push_ready, pop_valid, pop_priority, pop_data, tx_ready, flush,
        output enq_ready, push_valid, push_priority, push_data, pop, reinsert_priority, clear_all,
               tx_valid, tx_flow, tx_priority
    );

    modport slave (
        output enq_valid, enq_flow, push_ready, pop_valid, pop_priority, pop_data, tx_ready, flush,
        input  enq_ready, push_valid, push_priority, push_data, pop, reinsert_priority, clear_all,
               tx_valid, tx_flow, tx_priority
    );

endinterface

// File: rtl/pifo_pop_ctrl_flow_table.sv
// Per-flow backlog/active registers with an enq and a pop port merged per flow, plus a
// one-flow-per-cycle clear port; reads are combinational, updates land next cycle.
module pifo_pop_ctrl_flow_table
    import pifo_pop_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  flow_t       enq_flow,
    input  logic        enq_inc,
    input  logic        enq_activate,
    output flow_state_t enq_state,
    input  flow_t       pop_flow,
    input  logic        pop_dec,
    input  logic        pop_keep,
    output backlog_t    pop_backlog,
    input  logic        clr_en,
    input  flow_t       clr_flow
);

    flow_state_t st_q [NUM_FLOWS];
    flow_state_t st_d [NUM_FLOWS];

    assign enq_state   = st_q[enq_flow];
    assign pop_backlog = st_q[pop_flow].backlog;

    // Enq and pop of the same flow compose here, so a simultaneous +1/-1 nets to no change.
    always_comb begin
        for (int f = 0; f < NUM_FLOWS; f++) begin
            st_d[f] = st_q[f];
            if (clr_en && clr_flow == flow_t'(f)) begin
                st_d[f] = '0;
            end else begin
                if (enq_inc && enq_flow == flow_t'(f)) begin
                    st_d[f].backlog = st_d[f].backlog + backlog_t'(1);
                    if (enq_activate) begin
                        st_d[f].active = 1'b1;
                    end
                end
                if (pop_dec && pop_flow == flow_t'(f)) begin
                    st_d[f].backlog = st_d[f].backlog - backlog_t'(1);
                    st_d[f].active  = pop_keep;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int f = 0; f < NUM_FLOWS; f++) begin
            if (!reset) begin
                st_q[f] <= '0;
            end else begin
                st_q[f] <= st_d[f];
            end
        end
    end

endmodule

// File: rtl/pifo_pop_ctrl.sv
// Feeds newly backlogged flows into pifo_set, pops the head into a 1-cycle-latency descriptor
// register and reinserts it at a decayed priority; pops stall while the descriptor is held.
module pifo_pop_ctrl
    import pifo_pop_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    pifo_pop_ctrl_if.master bus
);

    state_t      state_q, state_d;
    flow_t       cnt_q, cnt_d;
    logic        clr_req;
    tx_desc_t    tx_q;
    logic        tx_vld_q;
    flow_state_t enq_st;
    backlog_t    pop_bl;
    logic        run_ok, enq_rdy, enq_acc, pop_go, same_flow, push_go, keep;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_req = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.flush) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                    clr_req = 1'b1;
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q + flow_t'(1);
                if (cnt_q == flow_t'(NUM_FLOWS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // A flush request preempts every handshake on its entry cycle.
    assign run_ok    = reset && (state_q == ST_RUN) && !bus.flush;
    assign enq_rdy   = run_ok && (enq_st.backlog != '1) && (enq_st.active || bus.push_ready);
    assign enq_acc   = bus.enq_valid && enq_rdy;
    assign pop_go    = run_ok && bus.pop_valid && (!tx_vld_q || bus.tx_ready);
    assign same_flow = enq_acc && pop_go && (bus.enq_flow == bus.pop_data);
    assign push_go   = enq_acc && !enq_st.active && !same_flow;
    assign keep      = same_flow ? (pop_bl != '0) : (pop_bl > backlog_t'(1));

    assign bus.enq_ready         = enq_rdy;
    assign bus.push_valid        = push_go;
    assign bus.push_priority     = push_go ? prio_t'(INIT_PRIO) : '0;
    assign bus.push_data         = push_go ? bus.enq_flow : '0;
    assign bus.pop               = pop_go;
    assign bus.reinsert_priority = (pop_go && keep) ? decay_prio(bus.pop_priority) : '0;
    assign bus.clear_all         = reset && clr_req;
    assign bus.tx_valid          = tx_vld_q;
    assign bus.tx_flow           = tx_q.flow;
    assign bus.tx_priority       = tx_q.prio;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_vld_q <= 1'b0;
            tx_q     <= '0;
        end else if (clr_req) begin
            tx_vld_q <= 1'b0;
            tx_q     <= '0;
        end else if (pop_go) begin
            tx_vld_q  <= 1'b1;
            tx_q.flow <= bus.pop_data;
            tx_q.prio <= bus.pop_priority;
        end else if (bus.tx_ready) begin
            tx_vld_q <= 1'b0;
        end
    end

    pifo_pop_ctrl_flow_table u_flow_table (
        .clk          (clk),
        .reset        (reset),
        .enq_flow     (bus.enq_flow),
        .enq_inc      (enq_acc),
        .enq_activate (push_go),
        .enq_state    (enq_st),
        .pop_flow     (bus.pop_data),
        .pop_dec      (pop_go),
        .pop_keep     (keep),
        .pop_backlog  (pop_bl),
        .clr_en       (state_q == ST_FLUSH),
        .clr_flow     (cnt_q)
    );

endmodule

// File: tb/tb_pifo_pop_ctrl.sv
// Bench for pifo_pop_ctrl: a behavioural PIFO plus per-flow backlog model drive and score the
// controller through directed scenarios followed by randomized traffic.
module tb_pifo_pop_ctrl;
    import pifo_pop_ctrl_pkg::*;

    localparam int BL_MAX = (1 << BACKLOG_WIDTH) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pifo_pop_ctrl_if bus ();

    pifo_pop_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_chk = 0;
    int n_err = 0;

    // reference state: backlog/active per flow, descriptor, flush countdown
    int bl [NUM_FLOWS];
    bit act [NUM_FLOWS];
    bit m_tx_v;
    int m_tx_f, m_tx_p;
    int flush_left;
    // environment PIFO contents
    bit in_p [NUM_FLOWS];
    int pp [NUM_FLOWS];

    int d_er, d_push, d_pp, d_pd, d_pop, d_rein, d_clr, d_txv, d_txf, d_txp;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic capture();
        d_er   = int'(bus.enq_ready);
        d_push = int'(bus.push_valid);
        d_pp   = int'(bus.push_priority);
        d_pd   = int'(bus.push_data);
        d_pop  = int'(bus.pop);
        d_rein = int'(bus.reinsert_priority);
        d_clr  = int'(bus.clear_all);
        d_txv  = int'(bus.tx_valid);
        d_txf  = int'(bus.tx_flow);
        d_txp  = int'(bus.tx_priority);
    endtask

    task automatic model_reset();
        for (int f = 0; f < NUM_FLOWS; f++) begin
            bl[f] = 0; act[f] = 0; in_p[f] = 0; pp[f] = 0;
        end
        m_tx_v = 0; m_tx_f = 0; m_tx_p = 0; flush_left = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.enq_valid = 1'b1; bus.enq_flow = flow_t'(3); bus.push_ready = 1'b1;
        bus.pop_valid = 1'b1; bus.pop_priority = prio_t'(200); bus.pop_data = flow_t'(2);
        bus.tx_ready = 1'b1; bus.flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            capture();
            chk("rst_enq_ready", d_er, 0);
            chk("rst_push_valid", d_push, 0);
            chk("rst_pop", d_pop, 0);
            chk("rst_reinsert", d_rein, 0);
            chk("rst_clear_all", d_clr, 0);
            chk("rst_tx_valid", d_txv, 0);
        end
        reset = 1'b1;
        model_reset();
    endtask

    // One clock of stimulus; ov forces the head priority to op.
    task automatic step(input bit ev, input int ef, input bit pr, input bit pe, input bit tr,
                        input bit fl, input bit ov, input int op);
        int h, hp, popp, net, ex_rein;
        bit have, run, ex_er, ex_acc, ex_pop, same, ex_push;
        have = 0; h = 0; hp = -1;
        for (int f = 0; f < NUM_FLOWS; f++) begin
            if (in_p[f] && pp[f] > hp) begin
                hp = pp[f]; h = f; have = 1;
            end
        end
        popp = ov ? op : hp;
        bus.enq_valid    = ev;
        bus.enq_flow     = flow_t'(ef);
        bus.push_ready   = pr;
        bus.pop_valid    = pe && have;
        bus.pop_data     = flow_t'(h);
        bus.pop_priority = prio_t'(have ? popp : 0);
        bus.tx_ready     = tr;
        bus.flush        = fl;
        #1;
        capture();

        run     = (flush_left == 0);
        ex_er   = run && !fl && (bl[ef] != BL_MAX) && (act[ef] || pr);
        ex_acc  = ev && ex_er;
        ex_pop  = run && !fl && pe && have && (!m_tx_v || tr);
        same    = ex_acc && ex_pop && (ef == h);
        ex_push = ex_acc && !act[ef] && !same;
        net     = bl[h] - 1 + int'(same);
        ex_rein = (ex_pop && net > 0) ? ((popp - PRIO_STEP < 1) ? 1 : popp - PRIO_STEP) : 0;

        chk("enq_ready", d_er, int'(ex_er));
        chk("push_valid", d_push, int'(ex_push));
        if (ex_push) begin
            chk("push_priority", d_pp, INIT_PRIO);
            chk("push_data", d_pd, ef);
        end
        chk("pop", d_pop, int'(ex_pop));
        chk("reinsert", d_rein, ex_rein);
        chk("clear_all", d_clr, int'(run && fl));
        chk("tx_valid", d_txv, int'(m_tx_v));
        if (m_tx_v) begin
            chk("tx_flow", d_txf, m_tx_f);
            chk("tx_priority", d_txp, m_tx_p);
        end

        @(posedge clk);
        if (!run) begin
            flush_left--;
        end else if (fl) begin
            for (int f = 0; f < NUM_FLOWS; f++) begin
                bl[f] = 0; act[f] = 0;
            end
            m_tx_v = 0;
            flush_left = NUM_FLOWS;
        end else begin
            if (ex_pop) begin
                m_tx_v = 1; m_tx_f = h; m_tx_p = popp;
            end else if (tr) begin
                m_tx_v = 0;
            end
            if (ex_acc) begin
                bl[ef]++;
                if (ex_push) act[ef] = 1;
            end
            if (ex_pop) begin
                bl[h]--;
                if (ex_rein == 0) act[h] = 0;
            end
        end

        // the environment PIFO follows what the DUT actually drove
        if (d_clr != 0) begin
            for (int f = 0; f < NUM_FLOWS; f++) in_p[f] = 0;
        end else begin
            if (d_pop != 0) begin
                if (d_rein != 0) pp[h] = d_rein;
                else in_p[h] = 0;
            end
            if (d_push != 0 && pr) begin
                in_p[d_pd] = 1;
                pp[d_pd] = d_pp;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        do_reset();

        // first arrival on an idle flow is pushed at the initial priority
        step(1, 3, 1, 0, 1, 0, 0, 0);
        chk("s1_push", d_push, 1);
        chk("s1_push_prio", d_pp, 255);
        chk("s1_push_data", d_pd, 3);

        // two packets on flow 3: decayed reinsert, then release
        step(1, 3, 1, 0, 1, 0, 0, 0);
        chk("s2_no_push", d_push, 0);
        step(0, 0, 1, 1, 1, 0, 0, 0);
        chk("s2_pop1_rein", d_rein, 239);
        step(0, 0, 1, 1, 1, 0, 0, 0);
        chk("s2_tx1_flow", d_txf, 3);
        chk("s2_tx1_prio", d_txp, 255);
        chk("s2_pop2_rein", d_rein, 0);
        step(0, 0, 1, 0, 1, 0, 0, 0);
        chk("s2_tx2_prio", d_txp, 239);
        step(1, 3, 1, 0, 1, 0, 0, 0);
        chk("s2_repush", d_push, 1);
        step(0, 0, 1, 1, 1, 0, 0, 0);
        chk("s2_drain", d_rein, 0);

        // pop and enq of the same flow in one cycle
        step(1, 5, 1, 0, 1, 0, 0, 0);
        step(1, 5, 1, 1, 1, 0, 0, 0);
        chk("s3_no_push", d_push, 0);
        chk("s3_rein", d_rein, 239);
        step(0, 0, 1, 1, 1, 0, 0, 0);
        chk("s3_last", d_rein, 0);

        // priority floor and backlog ceiling
        step(1, 6, 1, 0, 1, 0, 0, 0);
        step(1, 6, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 1, 0, 1, 10);
        chk("s4_sat", d_rein, 1);
        step(0, 0, 1, 1, 1, 0, 0, 0);
        chk("s4_drain", d_rein, 0);
        for (int i = 0; i < BL_MAX; i++) step(1, 7, 1, 0, 1, 0, 0, 0);
        step(1, 7, 1, 0, 1, 0, 0, 0);
        chk("s4_full_rdy", d_er, 0);
        step(1, 8, 1, 0, 1, 0, 0, 0);
        chk("s4_other_rdy", d_er, 1);

        // descriptor backpressure
        step(0, 0, 1, 1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0);
        chk("s5_bp_pop", d_pop, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0);
        chk("s5_hold_flow", d_txf, 7);
        chk("s5_hold_prio", d_txp, 255);
        step(0, 0, 1, 1, 1, 0, 0, 0);
        chk("s5_resume", d_pop, 1);

        // flush with several active flows
        step(1, 1, 1, 0, 1, 0, 0, 0);
        step(1, 2, 1, 0, 1, 0, 0, 0);
        step(1, 4, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 1, 1, 0, 0);
        chk("s6_clear", d_clr, 1);
        chk("s6_flush_no_pop", d_pop, 0);
        for (int i = 0; i < NUM_FLOWS; i++) begin
            step(1, 0, 1, 1, 1, i == 5, 0, 0);
            chk("s6_flush_rdy", d_er, 0);
        end
        step(1, 0, 1, 0, 1, 0, 0, 0);
        chk("s6_repush", d_push, 1);
        step(1, 7, 1, 0, 1, 0, 0, 0);
        chk("s6_bl7_cleared", d_push, 1);
        step(0, 0, 1, 1, 1, 0, 0, 0);
        chk("s6_pop_rein", d_rein, 0);

        // reset in the middle of a flush
        step(0, 0, 1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1, 0, 0, 0);
        do_reset();
        step(1, 2, 1, 0, 1, 0, 0, 0);
        chk("rst_flush_push", d_push, 1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, int'($urandom % 6), ($urandom % 8) != 0,
                 ($urandom % 3) != 0, ($urandom % 4) != 0, ($urandom % 250) == 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
